axi_stream_extract_header: RTL and testbench

- Receive-side counterpart of the header-insert stage. Sits directly downstream of it and consumes its AXI-Stream output.
- Per packet, strips the leading N header bytes (N = byte_strip_cnt+1, 1..DATA_BYTE_WD).
- Presents the header on a dedicated header port and re-aligns the remaining payload to MSB-first full beats.
- Byte order is MSB-first: byte 0 is data[DATA_WD-1 -: 8], keep bit DATA_BYTE_WD-1 belongs to byte 0, and keep is contiguous from the MSB.

---
 rtl/axi_stream_extract_header.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_extract_header.sv
// -----------------------------------------------------------------------------
// axi_stream_extract_header
//
// Purpose:
//   Receive-side header extractor for an AXI-Stream byte stream. For every
//   packet a strip request gives the header length N (byte_strip_cnt+1). The
//   first N bytes of the packet leave on the header port (left-aligned, zero
//   padded). The remaining bytes are re-packed into full MSB-first payload
//   beats, with only the final beat allowed to be partial.
//   Byte 0 of a beat is data[DATA_WD-1 -: 8]. Keep is contiguous from the MSB.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid_in/o_ready_in   input stream handshake
//   i_data_in/i_keep_in     input beat data and byte enables
//   i_last_in               final input beat of the packet
//   i_valid_strip/o_ready_strip
//                           strip-count request handshake
//   i_byte_strip_cnt        header length minus one
//   o_valid_header/i_ready_header
//                           header handshake (registered valid)
//   o_data_header/o_keep_header
//                           header bytes and enables
//   o_valid_out/i_ready_out payload handshake (registered valid)
//   o_data_out/o_keep_out   payload data and enables
//   o_last_out              final payload beat
// -----------------------------------------------------------------------------
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid_in,
  input  logic [DATA_WD-1:0]      i_data_in,
  input  logic [DATA_BYTE_WD-1:0] i_keep_in,
  input  logic                    i_last_in,
  output logic                    o_ready_in,
  input  logic                    i_valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  i_byte_strip_cnt,
  output logic                    o_ready_strip,
  output logic                    o_valid_header,
  output logic [DATA_WD-1:0]      o_data_header,
  output logic [DATA_BYTE_WD-1:0] o_keep_header,
  input  logic                    i_ready_header,
  output logic                    o_valid_out,
  output logic [DATA_WD-1:0]      o_data_out,
  output logic [DATA_BYTE_WD-1:0] o_keep_out,
  output logic                    o_last_out,
  input  logic                    i_ready_out
);

  // Byte counts range 0..DATA_BYTE_WD; the sum r+k ranges 0..2*DATA_BYTE_WD.
  localparam int CW = BYTE_CNT_WD + 1;
  localparam int SW = BYTE_CNT_WD + 2;

  typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

  // Keep mask with the top n bits set (n may exceed DATA_BYTE_WD -> all ones).
  function automatic logic [DATA_BYTE_WD-1:0] f_top_mask(input logic [SW-1:0] n);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      m[DATA_BYTE_WD-1-i] = (i < int'(n));
    end
    return m;
  endfunction

  // Expand a byte-enable mask to a bit mask over the data bus.
  function automatic logic [DATA_WD-1:0] f_byte_mask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      m[8*i +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

  function automatic logic [CW-1:0] f_popcount(input logic [DATA_BYTE_WD-1:0] keep);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      c = c + {{(CW-1){1'b0}}, keep[i]};
    end
    return c;
  endfunction

  // State and datapath registers
  state_t                  r_state;
  logic [CW-1:0]           r_n;       // header length N
  logic [CW-1:0]           r_r;       // bytes carried per beat, DATA_BYTE_WD-N
  logic [DATA_WD-1:0]      r_res;     // residual bytes, left-aligned, zero below
  logic [CW-1:0]           r_rc;      // residual byte count for the flush beat
  logic                    r_valid_header;
  logic [DATA_WD-1:0]      r_data_header;
  logic [DATA_BYTE_WD-1:0] r_keep_header;
  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;

  // Next-state values
  state_t                  w_state_next;
  logic [CW-1:0]           w_n_next;
  logic [CW-1:0]           w_r_next;
  logic [DATA_WD-1:0]      w_res_next;
  logic [CW-1:0]           w_rc_next;
  logic                    w_valid_header_next;
  logic [DATA_WD-1:0]      w_data_header_next;
  logic [DATA_BYTE_WD-1:0] w_keep_header_next;
  logic                    w_valid_out_next;
  logic [DATA_WD-1:0]      w_data_out_next;
  logic [DATA_BYTE_WD-1:0] w_keep_out_next;
  logic                    w_last_out_next;
  logic                    w_ready_in;
  logic                    w_ready_strip;

  // Shared combinational datapath
  logic                    w_po_free;
  logic                    w_ho_free;
  logic [CW-1:0]           w_k;
  logic [CW-1:0]           w_n_new;
  logic [DATA_WD-1:0]      w_shift_low;   // input bytes after the first N, left-aligned
  logic [DATA_WD-1:0]      w_merged;      // residual followed by top N input bytes
  logic [DATA_BYTE_WD-1:0] w_hdr_keep;
  logic [CW-1:0]           w_tail;        // k-N, floored at zero
  logic [CW-1:0]           w_rc_hdr;
  logic [SW-1:0]           w_sum;
  logic [DATA_BYTE_WD-1:0] w_sum_keep;
  logic [DATA_BYTE_WD-1:0] w_rc_hdr_keep;
  logic [DATA_BYTE_WD-1:0] w_rc_keep;

  assign w_po_free     = ~r_valid_out | i_ready_out;
  assign w_ho_free     = ~r_valid_header | i_ready_header;
  assign w_k           = f_popcount(i_keep_in);
  assign w_n_new       = CW'(i_byte_strip_cnt) + CW'(1);
  // A shift of 8*DATA_BYTE_WD (N = DATA_BYTE_WD) clears the vector, which is
  // exactly the empty residual needed for pass-through.
  assign w_shift_low   = i_data_in << {r_n, 3'b000};
  assign w_merged      = r_res | (i_data_in >> {r_r, 3'b000});
  assign w_hdr_keep    = f_top_mask(SW'(r_n)) & i_keep_in;
  assign w_tail        = (w_k > r_n) ? (w_k - r_n) : '0;
  assign w_rc_hdr      = (w_tail < r_r) ? w_tail : r_r;
  assign w_sum         = SW'(r_r) + SW'(w_k);
  assign w_sum_keep    = f_top_mask(w_sum);
  assign w_rc_hdr_keep = f_top_mask(SW'(w_rc_hdr));
  assign w_rc_keep     = f_top_mask(SW'(r_rc));

  always_comb begin
    w_state_next        = r_state;
    w_n_next            = r_n;
    w_r_next            = r_r;
    w_res_next          = r_res;
    w_rc_next           = r_rc;
    w_valid_header_next = r_valid_header & ~i_ready_header;
    w_data_header_next  = r_data_header;
    w_keep_header_next  = r_keep_header;
    w_valid_out_next    = r_valid_out & ~i_ready_out;
    w_data_out_next     = r_data_out;
    w_keep_out_next     = r_keep_out;
    w_last_out_next     = r_last_out;
    w_ready_in          = 1'b0;
    w_ready_strip       = 1'b0;

    case (r_state)
      IDLE: begin
        w_ready_strip = 1'b1;
        if (i_valid_strip) begin
          w_n_next     = w_n_new;
          w_r_next     = CW'(DATA_BYTE_WD) - w_n_new;
          w_state_next = HDR;
        end
      end

      HDR: begin
        // Both ports must have room: the header always loads, and a
        // single-beat packet may also load a payload beat.
        w_ready_in = w_ho_free & w_po_free;
        if (i_valid_in && w_ready_in) begin
          w_valid_header_next = 1'b1;
          w_keep_header_next  = w_hdr_keep;
          w_data_header_next  = i_data_in & f_byte_mask(w_hdr_keep);
          w_res_next          = w_shift_low;
          w_rc_next           = w_rc_hdr;
          if (i_last_in) begin
            if (w_rc_hdr != '0) begin
              w_valid_out_next = 1'b1;
              w_keep_out_next  = w_rc_hdr_keep;
              w_data_out_next  = w_shift_low & f_byte_mask(w_rc_hdr_keep);
              w_last_out_next  = 1'b1;
            end
            w_state_next = IDLE;
          end else begin
            w_state_next = BODY;
          end
        end
      end

      BODY: begin
        w_ready_in = w_po_free;
        if (i_valid_in && w_ready_in) begin
          w_valid_out_next = 1'b1;
          if (!i_last_in) begin
            w_data_out_next = w_merged;
            w_keep_out_next = '1;
            w_last_out_next = 1'b0;
            w_res_next      = w_shift_low;
          end else if (w_sum <= SW'(DATA_BYTE_WD)) begin
            w_data_out_next = w_merged & f_byte_mask(w_sum_keep);
            w_keep_out_next = w_sum_keep;
            w_last_out_next = 1'b1;
            w_state_next    = IDLE;
          end else begin
            // Packet tail spills past one beat: send a full beat now and the
            // k-N leftover bytes from the flush state.
            w_data_out_next = w_merged;
            w_keep_out_next = '1;
            w_last_out_next = 1'b0;
            w_res_next      = w_shift_low;
            w_rc_next       = w_tail;
            w_state_next    = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (w_po_free) begin
          w_valid_out_next = 1'b1;
          w_data_out_next  = r_res & f_byte_mask(w_rc_keep);
          w_keep_out_next  = w_rc_keep;
          w_last_out_next  = 1'b1;
          w_state_next     = IDLE;
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_n            <= '0;
      r_r            <= '0;
      r_res          <= '0;
      r_rc           <= '0;
      r_valid_header <= 1'b0;
      r_data_header  <= '0;
      r_keep_header  <= '0;
      r_valid_out    <= 1'b0;
      r_data_out     <= '0;
      r_keep_out     <= '0;
      r_last_out     <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_n            <= w_n_next;
      r_r            <= w_r_next;
      r_res          <= w_res_next;
      r_rc           <= w_rc_next;
      r_valid_header <= w_valid_header_next;
      r_data_header  <= w_data_header_next;
      r_keep_header  <= w_keep_header_next;
      r_valid_out    <= w_valid_out_next;
      r_data_out     <= w_data_out_next;
      r_keep_out     <= w_keep_out_next;
      r_last_out     <= w_last_out_next;
    end
  end

  assign o_ready_in     = w_ready_in;
  assign o_ready_strip  = w_ready_strip;
  assign o_valid_header = r_valid_header;
  assign o_data_header  = r_data_header;
  assign o_keep_header  = r_keep_header;
  assign o_valid_out    = r_valid_out;
  assign o_data_out     = r_data_out;
  assign o_keep_out     = r_keep_out;
  assign o_last_out     = r_last_out;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_extract_header
//
// Purpose:
//   Self-checking bench for axi_stream_extract_header. Expected header and
//   payload beats come from a byte-queue model: the packet is flattened to its
//   valid bytes, the first N go to the header, the rest are re-chunked into
//   DATA_BYTE_WD-byte beats. Directed cases plus randomized packets with
//   random backpressure on both output ports.
// -----------------------------------------------------------------------------
module tb_axi_stream_extract_header;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_strip = 1'b0;
  logic [1:0]  byte_strip_cnt = '0;
  logic        ready_strip;
  logic        valid_header;
  logic [31:0] data_header;
  logic [3:0]  keep_header;
  logic        ready_header = 1'b1;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;

  int n_checks = 0;
  int n_pass = 0;
  logic [63:0] exp_hdr_q[$];
  logic [63:0] exp_pay_q[$];
  logic [31:0] pd[8];
  logic [3:0]  pk[8];
  bit bp_en = 1'b0;
  bit abort = 1'b0;
  int pkt_id = 0;

  always #5 clk = ~clk;

  axi_stream_extract_header #(.DATA_WD(32)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_valid_in       (valid_in),
    .i_data_in        (data_in),
    .i_keep_in        (keep_in),
    .i_last_in        (last_in),
    .o_ready_in       (ready_in),
    .i_valid_strip    (valid_strip),
    .i_byte_strip_cnt (byte_strip_cnt),
    .o_ready_strip    (ready_strip),
    .o_valid_header   (valid_header),
    .o_data_header    (data_header),
    .o_keep_header    (keep_header),
    .i_ready_header   (ready_header),
    .o_valid_out      (valid_out),
    .o_data_out       (data_out),
    .o_keep_out       (keep_out),
    .o_last_out       (last_out),
    .i_ready_out      (ready_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [3:0] top_k(input int k);
    logic [3:0] m;
    m = 4'hF;
    m = m << (4 - k);
    return m;
  endfunction

  // Reference: flatten valid bytes, split off header, re-chunk the rest.
  task automatic model_pkt(input int cnt, input int nb);
    logic [7:0]  q[$];
    logic [31:0] d;
    logic [31:0] w;
    logic [3:0]  m;
    int n, k0, hn;
    n  = cnt + 1;
    k0 = $countones(pk[0]);
    hn = (n < k0) ? n : k0;
    d = '0; m = '0; w = pd[0];
    for (int i = 0; i < hn; i++) begin
      d[31-8*i -: 8] = w[31-8*i -: 8];
      m[3-i] = 1'b1;
    end
    exp_hdr_q.push_back({28'b0, d, m});
    for (int i = n; i < k0; i++) q.push_back(w[31-8*i -: 8]);
    for (int b = 1; b < nb; b++) begin
      w = pd[b];
      for (int i = 0; i < $countones(pk[b]); i++) q.push_back(w[31-8*i -: 8]);
    end
    while (q.size() > 0) begin
      d = '0; m = '0;
      for (int i = 0; i < 4 && q.size() > 0; i++) begin
        d[31-8*i -: 8] = q.pop_front();
        m[3-i] = 1'b1;
      end
      exp_pay_q.push_back({27'b0, (q.size() == 0), m, d});
    end
  endtask

  task automatic send_pkt(input int cnt, input int nb);
    int t;
    model_pkt(cnt, nb);
    $display("pkt %0d: strip_cnt=%0d beats=%0d first=%h last_keep=%b", pkt_id, cnt, nb, pd[0], pk[nb-1]);
    pkt_id++;
    valid_strip = 1'b1;
    byte_strip_cnt = 2'(cnt);
    t = 0;
    @(negedge clk);
    while (!ready_strip && !abort && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) chk("strip_timeout", {63'b0, ready_strip}, 64'd1);
    if (abort || t >= 1000) begin valid_strip = 1'b0; return; end
    @(posedge clk); #1;
    valid_strip = 1'b0;
    for (int b = 0; b < nb; b++) begin
      valid_in = 1'b1; data_in = pd[b]; keep_in = pk[b]; last_in = (b == nb - 1);
      t = 0;
      @(negedge clk);
      while (!ready_in && !abort && t < 1000) begin @(negedge clk); t++; end
      if (t >= 1000) chk("in_timeout", {63'b0, ready_in}, 64'd1);
      if (abort || t >= 1000) begin valid_in = 1'b0; last_in = 1'b0; return; end
      @(posedge clk); #1;
      if (!abort) begin
        if (b == 0) chk("hdr_latency", {63'b0, valid_header}, 64'd1);
        if (b > 0 || (nb == 1 && $countones(pk[0]) > cnt + 1))
          chk("pay_latency", {63'b0, valid_out}, 64'd1);
      end
    end
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  // Output monitors: a transfer seen at the negedge completes on the next posedge.
  initial begin : mon
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid_header && ready_header) begin
          e = (exp_hdr_q.size() > 0) ? exp_hdr_q.pop_front() : '1;
          chk("hdr", {28'b0, data_header, keep_header}, e);
        end
        if (valid_out && ready_out) begin
          e = (exp_pay_q.size() > 0) ? exp_pay_q.pop_front() : '1;
          chk("payload", {27'b0, last_out, keep_out, data_out}, e);
        end
      end
    end
  end

  initial begin : bp
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        ready_out    = ($urandom_range(0, 3) != 0);
        ready_header = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : main
    int t, cnt, nb;
    // Reset state
    @(negedge clk);
    chk("rst_valid_out", {63'b0, valid_out}, 64'd0);
    chk("rst_valid_hdr", {63'b0, valid_header}, 64'd0);
    chk("rst_last_out", {63'b0, last_out}, 64'd0);
    chk("rst_data_out", {32'b0, data_out}, 64'd0);
    chk("rst_hdr", {28'b0, data_header, keep_header}, 64'd0);
    chk("rst_keep_out", {60'b0, keep_out}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready_strip", {63'b0, ready_strip}, 64'd1);
    chk("idle_ready_in", {63'b0, ready_in}, 64'd0);

    // Case 1: N=2, three beats, flush path
    pd[0] = 32'hA1A2A3A4; pk[0] = 4'hF;
    pd[1] = 32'hB1B2B3B4; pk[1] = 4'hF;
    pd[2] = 32'hC1C2C3C4; pk[2] = 4'hE;
    send_pkt(1, 3);
    // Case 2: N=3, single-beat output
    pd[0] = 32'h11223344; pk[0] = 4'hF;
    pd[1] = 32'h55667788; pk[1] = 4'hC;
    send_pkt(2, 2);
    // Case 3: N=4, pass-through
    pd[0] = 32'hDEADBEEF; pk[0] = 4'hF;
    pd[1] = 32'h01020304; pk[1] = 4'hF;
    pd[2] = 32'h05060700; pk[2] = 4'hE;
    send_pkt(3, 3);
    // Case 4: header-only single beat
    pd[0] = 32'hA1A2A3A4; pk[0] = 4'hC;
    send_pkt(1, 1);
    chk("sb_no_valid_out", {63'b0, valid_out}, 64'd0);
    chk("sb_ready_strip", {63'b0, ready_strip}, 64'd1);
    @(negedge clk);
    chk("sb_no_valid_out2", {63'b0, valid_out}, 64'd0);

    // Payload backpressure on case 1
    repeat (2) @(posedge clk); #1;
    ready_out = 1'b0;
    pd[0] = 32'hA1A2A3A4; pk[0] = 4'hF;
    pd[1] = 32'hB1B2B3B4; pk[1] = 4'hF;
    pd[2] = 32'hC1C2C3C4; pk[2] = 4'hE;
    fork
      send_pkt(1, 3);
      begin
        t = 0;
        while (!valid_out && t < 1000) begin @(negedge clk); t++; end
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold_data", {32'b0, data_out}, {32'b0, 32'hA3A4B1B2});
          chk("bp_valid_out", {63'b0, valid_out}, 64'd1);
          chk("bp_ready_in", {63'b0, ready_in}, 64'd0);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
      end
    join

    // Held header stalls only the next packet's first beat
    ready_header = 1'b0;
    pd[0] = 32'hA1A2A3A4; pk[0] = 4'hF;
    fork
      begin
        send_pkt(0, 1);
        pd[0] = 32'h11223344; pk[0] = 4'hF;
        pd[1] = 32'h55667788; pk[1] = 4'hC;
        send_pkt(2, 2);
      end
      begin
        t = 0;
        while (!valid_header && t < 1000) begin @(negedge clk); t++; end
        repeat (3) begin
          @(negedge clk);
          chk("hs_hold_hdr", {32'b0, data_header}, {32'b0, 32'hA1000000});
          chk("hs_ready_in", {63'b0, ready_in}, 64'd0);
        end
        @(posedge clk); #1;
        ready_header = 1'b1;
      end
    join

    // Asynchronous reset in the middle of the body
    repeat (2) @(posedge clk); #1;
    pd[0] = 32'h10203040; pk[0] = 4'hF;
    for (int b = 1; b < 5; b++) begin pd[b] = $urandom; pk[b] = 4'hF; end
    fork
      send_pkt(1, 5);
      begin
        t = 0;
        while (!valid_out && t < 1000) begin @(negedge clk); t++; end
        @(negedge clk); #2;
        rst_n = 1'b0;
        abort = 1'b1;
        exp_hdr_q.delete();
        exp_pay_q.delete();
        #1;
        chk("arst_valid_out", {63'b0, valid_out}, 64'd0);
        chk("arst_valid_hdr", {63'b0, valid_header}, 64'd0);
        chk("arst_last_out", {63'b0, last_out}, 64'd0);
        chk("arst_ready_in", {63'b0, ready_in}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
      end
    join
    abort = 1'b0;
    @(posedge clk); #1;
    chk("arst_ready_strip", {63'b0, ready_strip}, 64'd1);
    pd[0] = 32'hDEADBEEF; pk[0] = 4'hF;
    pd[1] = 32'h01020304; pk[1] = 4'hF;
    pd[2] = 32'h05060700; pk[2] = 4'hE;
    send_pkt(3, 3);

    // Randomized packets with random backpressure
    bp_en = 1'b1;
    for (int p = 0; p < 150; p++) begin
      cnt = $urandom_range(0, 3);
      nb  = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        pd[b] = $urandom;
        pk[b] = (b < nb - 1) ? 4'hF : top_k($urandom_range(1, 4));
      end
      send_pkt(cnt, nb);
    end
    bp_en = 1'b0;
    @(posedge clk); #2;
    ready_out = 1'b1;
    ready_header = 1'b1;
    t = 0;
    while ((exp_hdr_q.size() > 0 || exp_pay_q.size() > 0) && t < 1000) begin
      @(negedge clk); t++;
    end
    @(negedge clk);
    chk("hdr_left", 64'(exp_hdr_q.size()), 64'd0);
    chk("pay_left", 64'(exp_pay_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
